// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush sequencer for the 5-stage pipeline.
// Drives PC, IF/ID and ID/EX hold and bubble controls for three cases:
// load-use hazards, multi-cycle float/convolution ops in EX, and
// branch mispredict flushes. Also keeps two saturating perf counters.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_RUN      | normal issue; mispredict, fp start and load-use checked here
// ST_FP_WAIT  | multi-cycle op owns EX; whole front end held until done
// ST_RECOVER  | remaining flush cycles after an accepted mispredict
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 1,
    parameter int FP_TIMEOUT   = 64,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [4:0]       if_id_register_rs1,
    input  logic [4:0]       if_id_register_rs2,
    input  logic             if_id_rs1_sel,
    input  logic             if_id_rs2_sel,
    input  logic             if_id_valid,
    input  logic             id_ex_memread,
    input  logic [4:0]       id_ex_register_rd,
    input  logic             id_ex_rd_sel,
    input  logic             ex_mispredict,
    input  logic             ex_fp_start,
    input  logic             fp_done,
    input  logic             cnt_clr,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             id_ex_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             fp_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Timeout counter only needs to reach FP_TIMEOUT-1.
    localparam int TMO_W = (FP_TIMEOUT > 1) ? $clog2(FP_TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST   = TMO_W'(FP_TIMEOUT - 1);
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_FP_WAIT = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t           state;
    logic [TMO_W-1:0] tmo_cnt;
    logic [2:0]       flush_cnt;

    logic rs1_hit;
    logic rs2_hit;
    logic rd_real;
    logic lu;
    logic accept_mp;

    // Load-use detect; integer x0 is hardwired so it never creates a hazard,
    // but float f0 is an ordinary register.
    always_comb begin
        rs1_hit = (if_id_register_rs1 == id_ex_register_rd) && (if_id_rs1_sel == id_ex_rd_sel);
        rs2_hit = (if_id_register_rs2 == id_ex_register_rd) && (if_id_rs2_sel == id_ex_rd_sel);
        rd_real = id_ex_rd_sel || (id_ex_register_rd != 5'd0);
        lu      = if_id_valid && id_ex_memread && rd_real && (rs1_hit || rs2_hit);
    end

    assign accept_mp = (state == ST_RUN) && ex_mispredict;

    // Stall/flush outputs decoded from state and live inputs; all held low in reset.
    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        id_ex_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (reset_n) begin
            case (state)
                ST_RUN: begin
                    if (ex_mispredict) begin
                        if_id_flush = 1'b1;
                        id_ex_flush = 1'b1;
                    end else if (ex_fp_start) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_stall = 1'b1;
                    end else if (lu) begin
                        pc_stall    = 1'b1;
                        if_id_stall = 1'b1;
                        id_ex_flush = 1'b1;
                    end
                end
                ST_FP_WAIT: begin
                    pc_stall    = 1'b1;
                    if_id_stall = 1'b1;
                    id_ex_stall = 1'b1;
                end
                ST_RECOVER: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_stall = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, wait/flush counters and sticky timeout flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_RUN;
            tmo_cnt    <= '0;
            flush_cnt  <= '0;
            fp_timeout <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (ex_mispredict) begin
                        // A single-cycle flush is fully covered by this RUN cycle.
                        if (FLUSH_CYCLES > 1) begin
                            state     <= ST_RECOVER;
                            flush_cnt <= FLUSH_INIT;
                        end
                    end else if (ex_fp_start) begin
                        state   <= ST_FP_WAIT;
                        tmo_cnt <= '0;
                    end
                end
                ST_FP_WAIT: begin
                    if (fp_done) begin
                        state <= ST_RUN;
                    end else if (tmo_cnt == TMO_LAST) begin
                        fp_timeout <= 1'b1;
                        state      <= ST_RUN;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                ST_RECOVER: begin
                    if (flush_cnt <= 3'd1) begin
                        state <= ST_RUN;
                    end else begin
                        flush_cnt <= flush_cnt - 3'd1;
                    end
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

    // Saturating perf counters; a clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else if (cnt_clr) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (pc_stall && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (accept_mp && (flush_events != CNT_MAX)) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a behavioural model of the sequencing rules.
module tb_pipe_hazard_ctrl;

    localparam int FLUSH_CYCLES = 3;
    localparam int FP_TIMEOUT   = 8;
    localparam int CNT_W        = 4;
    localparam int CNT_MAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [4:0]       if_id_register_rs1;
    logic [4:0]       if_id_register_rs2;
    logic             if_id_rs1_sel;
    logic             if_id_rs2_sel;
    logic             if_id_valid;
    logic             id_ex_memread;
    logic [4:0]       id_ex_register_rd;
    logic             id_ex_rd_sel;
    logic             ex_mispredict;
    logic             ex_fp_start;
    logic             fp_done;
    logic             cnt_clr;
    logic             pc_stall;
    logic             if_id_stall;
    logic             id_ex_stall;
    logic             if_id_flush;
    logic             id_ex_flush;
    logic             fp_timeout;
    logic [CNT_W-1:0] stall_cycles;
    logic [CNT_W-1:0] flush_events;

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .FP_TIMEOUT  (FP_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .if_id_register_rs1(if_id_register_rs1),
        .if_id_register_rs2(if_id_register_rs2),
        .if_id_rs1_sel     (if_id_rs1_sel),
        .if_id_rs2_sel     (if_id_rs2_sel),
        .if_id_valid       (if_id_valid),
        .id_ex_memread     (id_ex_memread),
        .id_ex_register_rd (id_ex_register_rd),
        .id_ex_rd_sel      (id_ex_rd_sel),
        .ex_mispredict     (ex_mispredict),
        .ex_fp_start       (ex_fp_start),
        .fp_done           (fp_done),
        .cnt_clr           (cnt_clr),
        .pc_stall          (pc_stall),
        .if_id_stall       (if_id_stall),
        .id_ex_stall       (id_ex_stall),
        .if_id_flush       (if_id_flush),
        .id_ex_flush       (id_ex_flush),
        .fp_timeout        (fp_timeout),
        .stall_cycles      (stall_cycles),
        .flush_events      (flush_events)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: "is a float op outstanding and how long has it waited",
    // "how many flush cycles are still owed", sticky error, counter values.
    bit m_fp_busy;
    int m_fp_waited;
    int m_flush_left;
    bit m_tmo;
    int m_stalls;
    int m_flushes;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_fp_busy    = 1'b0;
        m_fp_waited  = 0;
        m_flush_left = 0;
        m_tmo        = 1'b0;
        m_stalls     = 0;
        m_flushes    = 0;
    endtask

    function automatic bit hazard();
        bit x0 = !id_ex_rd_sel && (id_ex_register_rd == 5'd0);
        bit m1 = (if_id_register_rs1 == id_ex_register_rd) && (if_id_rs1_sel == id_ex_rd_sel);
        bit m2 = (if_id_register_rs2 == id_ex_register_rd) && (if_id_rs2_sel == id_ex_rd_sel);
        return if_id_valid && id_ex_memread && !x0 && (m1 || m2);
    endfunction

    // One clock: entered just after a falling edge with inputs already set.
    task automatic step();
        bit e_pc, e_ifs, e_ids, e_iff, e_idf, mp_taken;
        #1;
        if (!reset_n) model_reset();
        {e_pc, e_ifs, e_ids, e_iff, e_idf, mp_taken} = '0;
        if (reset_n) begin
            if (m_fp_busy) begin
                {e_pc, e_ifs, e_ids} = 3'b111;
            end else if (m_flush_left > 0) begin
                {e_iff, e_idf} = 2'b11;
            end else if (ex_mispredict) begin
                {e_iff, e_idf} = 2'b11;
                mp_taken = 1'b1;
            end else if (ex_fp_start) begin
                {e_pc, e_ifs, e_ids} = 3'b111;
            end else if (hazard()) begin
                {e_pc, e_ifs, e_idf} = 3'b111;
            end
        end
        chk("pc_stall", 32'(pc_stall), 32'(e_pc));
        chk("if_id_stall", 32'(if_id_stall), 32'(e_ifs));
        chk("id_ex_stall", 32'(id_ex_stall), 32'(e_ids));
        chk("if_id_flush", 32'(if_id_flush), 32'(e_iff));
        chk("id_ex_flush", 32'(id_ex_flush), 32'(e_idf));
        chk("stall_flush_excl", 32'(id_ex_stall & id_ex_flush), 32'd0);
        chk("fp_timeout", 32'(fp_timeout), 32'(m_tmo));
        chk("stall_cycles", 32'(stall_cycles), 32'(m_stalls));
        chk("flush_events", 32'(flush_events), 32'(m_flushes));
        if (reset_n) begin
            if (m_fp_busy) begin
                if (fp_done) begin
                    m_fp_busy = 1'b0;
                end else if (m_fp_waited + 1 == FP_TIMEOUT) begin
                    m_fp_busy = 1'b0;
                    m_tmo     = 1'b1;
                end else begin
                    m_fp_waited++;
                end
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (mp_taken) begin
                m_flush_left = FLUSH_CYCLES - 1;
            end else if (ex_fp_start) begin
                m_fp_busy   = 1'b1;
                m_fp_waited = 0;
            end
            if (cnt_clr) begin
                m_stalls  = 0;
                m_flushes = 0;
            end else begin
                if (e_pc && m_stalls < CNT_MAX) m_stalls++;
                if (mp_taken && m_flushes < CNT_MAX) m_flushes++;
            end
        end
        @(negedge clk);
    endtask

    task automatic idle();
        if_id_register_rs1 = 5'd0;
        if_id_register_rs2 = 5'd0;
        if_id_rs1_sel      = 1'b0;
        if_id_rs2_sel      = 1'b0;
        if_id_valid        = 1'b0;
        id_ex_memread      = 1'b0;
        id_ex_register_rd  = 5'd0;
        id_ex_rd_sel       = 1'b0;
        ex_mispredict      = 1'b0;
        ex_fp_start        = 1'b0;
        fp_done            = 1'b0;
        cnt_clr            = 1'b0;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic rd_sel,
                          input logic [4:0] rs1, input logic s1,
                          input logic [4:0] rs2, input logic s2);
        idle();
        if_id_valid        = 1'b1;
        id_ex_memread      = 1'b1;
        id_ex_register_rd  = rd;
        id_ex_rd_sel       = rd_sel;
        if_id_register_rs1 = rs1;
        if_id_rs1_sel      = s1;
        if_id_register_rs2 = rs2;
        if_id_rs2_sel      = s2;
    endtask

    task automatic clear_counters();
        idle();
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        idle();
        model_reset();
        @(negedge clk);
        step();
        step();
        reset_n = 1'b1;
        step();

        // load-use on integer x5, then load moves on
        set_lu(5'd5, 1'b0, 5'd5, 1'b0, 5'd9, 1'b0);
        step();
        id_ex_memread = 1'b0;
        step();
        chk("lu_stall_count", 32'(stall_cycles), 32'd1);

        // false-hazard filters, then float f0 which does match
        set_lu(5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0);
        step();
        set_lu(5'd3, 1'b1, 5'd8, 1'b0, 5'd3, 1'b0);
        step();
        set_lu(5'd0, 1'b1, 5'd0, 1'b1, 5'd6, 1'b0);
        step();
        chk("f0_stall_count", 32'(stall_cycles), 32'd2);

        // clear together with a stall leaves zero
        set_lu(5'd4, 1'b0, 5'd1, 1'b0, 5'd4, 1'b0);
        cnt_clr = 1'b1;
        step();
        chk("clr_beats_inc", 32'(stall_cycles), 32'd0);

        // fp op completing four cycles after start
        clear_counters();
        idle();
        ex_fp_start = 1'b1;
        step();
        ex_fp_start = 1'b0;
        repeat (3) step();
        fp_done = 1'b1;
        step();
        fp_done = 1'b0;
        step();
        chk("fp_stall_count", 32'(stall_cycles), 32'd5);

        // fp op never completing
        idle();
        ex_fp_start = 1'b1;
        step();
        ex_fp_start = 1'b0;
        repeat (FP_TIMEOUT) step();
        step();
        chk("tmo_flag_set", 32'(fp_timeout), 32'd1);
        repeat (3) step();
        chk("tmo_flag_sticky", 32'(fp_timeout), 32'd1);

        // mispredict with a concurrent load-use, second mispredict ignored
        clear_counters();
        set_lu(5'd5, 1'b0, 5'd5, 1'b0, 5'd0, 1'b0);
        ex_mispredict = 1'b1;
        step();
        step();
        step();
        idle();
        step();
        chk("mp_events", 32'(flush_events), 32'd1);

        // saturation of the stall counter
        clear_counters();
        set_lu(5'd2, 1'b0, 5'd2, 1'b0, 5'd0, 1'b0);
        repeat (20) step();
        chk("stall_saturate", 32'(stall_cycles), 32'(CNT_MAX));

        // reset in the middle of an fp wait
        idle();
        ex_fp_start = 1'b1;
        step();
        ex_fp_start = 1'b0;
        repeat (2) step();
        reset_n = 1'b0;
        step();
        chk("rst_mid_fp_stall", 32'(pc_stall), 32'd0);
        chk("rst_mid_fp_cnt", 32'(stall_cycles), 32'd0);
        reset_n = 1'b1;
        step();

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            if_id_register_rs1 = 5'($urandom_range(0, 3));
            if_id_register_rs2 = 5'($urandom_range(0, 3));
            id_ex_register_rd  = 5'($urandom_range(0, 3));
            if_id_rs1_sel      = 1'($urandom_range(0, 1));
            if_id_rs2_sel      = 1'($urandom_range(0, 1));
            id_ex_rd_sel       = 1'($urandom_range(0, 1));
            if_id_valid        = ($urandom_range(0, 3) != 0);
            id_ex_memread      = 1'($urandom_range(0, 1));
            ex_mispredict      = ($urandom_range(0, 11) == 0);
            ex_fp_start        = ($urandom_range(0, 9) == 0);
            fp_done            = ($urandom_range(0, 4) == 0);
            cnt_clr            = ($urandom_range(0, 63) == 0);
            reset_n            = ($urandom_range(0, 299) != 0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage RISC-V pipeline. It drives the stall and flush inputs of the PC, IF/ID and ID/EX pipeline registers.
- Detects load-use hazards across the integer and float register files.
- Holds the pipeline while a multi-cycle float/convolution op occupies EX.
- Issues flush sequences on branch-predictor mispredicts.
- Keeps saturating performance counters for stall cycles and mispredict events.

Parameters:
FLUSH_CYCLES, 1, total cycles flush is held after a mispredict (legal range 1..7)
FP_TIMEOUT, 64, maximum FP_WAIT cycles before forced exit and error flag
CNT_W, 16, width of performance counters

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_id_register_rs1  in  5  rs1 index of instruction in ID
if_id_register_rs2  in  5  rs2 index of instruction in ID
if_id_rs1_sel  in  1  1 = rs1 reads the float file
if_id_rs2_sel  in  1  1 = rs2 reads the float file
if_id_valid  in  1  ID holds a real instruction
id_ex_memread  in  1  instruction in EX is a load
id_ex_register_rd  in  5  rd of instruction in EX
id_ex_rd_sel  in  1  1 = rd writes the float file
ex_mispredict  in  1  branch resolved in EX disagrees with prediction
ex_fp_start  in  1  multi-cycle float op begins in EX this cycle
fp_done  in  1  multi-cycle unit result ready
cnt_clr  in  1  synchronous clear of both counters
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
id_ex_stall  out  1  hold ID/EX
if_id_flush  out  1  zero IF/ID
id_ex_flush  out  1  bubble ID/EX (controls to 0)
fp_timeout  out  1  sticky error, FP_WAIT timed out
stall_cycles  out  CNT_W  count of cycles with pc_stall=1
flush_events  out  CNT_W  count of accepted mispredicts

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=RUN; timeout and flush counters=0; fp_timeout=0; both perf counters=0.
  - All five stall/flush outputs are forced 0 while reset_n=0.
- Stall/flush outputs are combinational from state and current inputs. State, counters and flags update on the rising edge of clk.
- States: RUN, FP_WAIT, RECOVER.
- Load-use hazard (lu), evaluated only in RUN:
  - Requires if_id_valid & id_ex_memread, plus a match on either source:
    - rs1: rs1==rd and rs1_sel==rd_sel; or
    - rs2: rs2==rd and rs2_sel==rd_sel.
  - An integer rd=0 never matches. Float f0 does match.
- RUN priority (highest first):
  1. ex_mispredict: if_id_flush=1, id_ex_flush=1, no stalls. flush_events+1.
     - FLUSH_CYCLES>1: go to RECOVER with remaining count FLUSH_CYCLES-1.
     - FLUSH_CYCLES=1: stay in RUN.
     - ex_fp_start and lu are ignored this cycle.
  2. ex_fp_start: pc_stall=if_id_stall=id_ex_stall=1 this cycle; next state FP_WAIT; timeout counter cleared.
  3. lu: pc_stall=1, if_id_stall=1, id_ex_flush=1 (one bubble), id_ex_stall=0; stay in RUN.
     - lu reevaluates next cycle; with the load now in MEM it clears.
  4. Otherwise all outputs 0.
- FP_WAIT:
  - pc_stall=if_id_stall=id_ex_stall=1 every cycle, including the cycle fp_done is high.
  - fp_done=1 → RUN next edge.
  - Else timeout counter +1. When it reaches FP_TIMEOUT-1, set fp_timeout=1 (sticky until reset) and go to RUN.
  - ex_mispredict, ex_fp_start and lu are ignored in this state.
- RECOVER:
  - if_id_flush=1, id_ex_flush=1, no stalls. Remaining count decrements each cycle; at 1 → RUN.
  - ex_mispredict, ex_fp_start and lu are ignored (those instructions are being flushed).
- Invariant: id_ex_stall and id_ex_flush are never both 1.
- Counters:
  - stall_cycles increments in every cycle with pc_stall=1.
  - Both counters saturate at all-ones.
  - cnt_clr=1 zeroes both counters and takes priority over an increment in the same cycle.

Test Plan:
- Load-use: EX lw rd=5 (memread=1, rd_sel=0); ID rs1=5, rs1_sel=0, valid=1 → one cycle of pc_stall=1, if_id_stall=1, id_ex_flush=1. Deasserts once memread=0. stall_cycles=1.
- No false hazards: rd=0 with rs1=0 → no stall. rd=3 with rd_sel=1 against rs2=3, rs2_sel=0 → no stall. rd_sel=1, rd=0 against rs1=0, rs1_sel=1 → stall.
- FP wait: ex_fp_start pulse, fp_done raised 4 cycles later → stalls high for 5 cycles total (start cycle + 4 FP_WAIT cycles), then all 0. stall_cycles=5.
- Timeout: FP_TIMEOUT=8, fp_done never asserted → FSM returns to RUN after 8 FP_WAIT cycles. fp_timeout=1 and remains 1 until reset_n.
- Mispredict: FLUSH_CYCLES=3, ex_mispredict asserted together with lu → no stall; if_id_flush and id_ex_flush high 3 cycles; a second ex_mispredict during RECOVER is ignored. flush_events=1.
- Reset/counters: reset_n dropped mid-FP_WAIT → outputs 0 immediately, state RUN, counters 0. Force saturation at CNT_W=4 → holds at 15. cnt_clr together with a stall → counter reads 0.
